dcache_load_pipe: RTL

Parametrised three-stage DCache load pipeline that generalises the existing fixed-associativity load path. It adds configurable ways, bank width and tag offset, per-stage valid/ready flow control, flush, and tree-PLRU victim selection that prefers invalid ways. Byte, halfword and word loads get misalignment detection. It sits between the LSU address-generation stage and the DCache tag/meta/data arrays, TLB and miss handler.

---
 rtl/dcache_load_pipe.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_load_pipe.sv
// dcache_load_pipe: three-stage DCache load pipeline.
//   s0: request handshake, tag/meta array read enable (arr_req_o).
//   s1: translation, tag compare, victim selection (invalid-first, then tree-PLRU),
//       PLRU writeback, data array read request.
//   s2: data capture/hold, word select, byte/half extension, miss/misalign result.
// Ports: clk, rst (sync, active-high), flush_i, s0_* request, s1_* TLB/tag/meta/PLRU
//   inputs and replacement/PLRU outputs, s2_* bank data input and result handshake.
// Optional feature macro: LOAD_PIPE_HUGE_PAGE_EN (enables 2 MiB translation via s1_huge_i).
module dcache_load_pipe #(
    parameter int unsigned WAYS       = 4,
    parameter int unsigned BANK_WORDS = 2,
    parameter int unsigned VALEN      = 32,
    parameter int unsigned PALEN      = 32,
    parameter int unsigned TAG_OFFSET = 12
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush_i,
    input  logic                             s0_valid_i,
    output logic                             s0_ready_o,
    input  logic [VALEN-1:0]                 s0_vaddr_i,
    input  logic [2:0]                       s0_align_i,
    output logic                             arr_req_o,
    input  logic [PALEN-13:0]                s1_ppn_i,
    input  logic                             s1_huge_i,
    input  logic [WAYS*(PALEN-TAG_OFFSET)-1:0] s1_tag_i,
    input  logic [WAYS-1:0]                  s1_meta_valid_i,
    input  logic [WAYS-2:0]                  s1_plru_i,
    input  logic                             s1_bank_conflict_i,
    output logic                             s1_data_req_o,
    output logic [PALEN-1:0]                 s1_paddr_o,
    output logic [WAYS-2:0]                  s1_plru_o,
    output logic                             s1_plru_we_o,
    output logic [$clog2(WAYS)-1:0]          s1_victim_way_o,
    output logic [PALEN-1:0]                 s1_victim_paddr_o,
    input  logic [WAYS*BANK_WORDS*32-1:0]    s2_data_i,
    output logic                             s2_valid_o,
    input  logic                             s2_ready_i,
    output logic [31:0]                      s2_data_o,
    output logic                             s2_miss_o,
    output logic                             s2_ale_o,
    output logic [PALEN-1:0]                 s2_paddr_o
);

    localparam int unsigned TAGW   = PALEN - TAG_OFFSET;
    localparam int unsigned WAY_W  = $clog2(WAYS);
    localparam int unsigned WIDX_W = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;

    localparam logic [2:0] ALIGN_TYPE_B  = 3'd0;
    localparam logic [2:0] ALIGN_TYPE_H  = 3'd1;
    localparam logic [2:0] ALIGN_TYPE_W  = 3'd2;
    localparam logic [2:0] ALIGN_TYPE_BU = 3'd4;
    localparam logic [2:0] ALIGN_TYPE_HU = 3'd5;

    logic              s1_v_q, s1_v_d;
    logic [VALEN-1:0]  s1_vaddr_q, s1_vaddr_d;
    logic [2:0]        s1_align_q, s1_align_d;
    logic              s2_v_q, s2_v_d;
    logic              s2_first_q, s2_first_d;
    logic [PALEN-1:0]  s2_paddr_q, s2_paddr_d;
    logic [2:0]        s2_align_q, s2_align_d;
    logic [WAY_W-1:0]  s2_way_q, s2_way_d;
    logic              s2_miss_q, s2_miss_d;
    logic              s2_ale_q, s2_ale_d;
    logic [31:0]       s2_hold_q, s2_hold_d;

    logic              s0_fire, s1_adv;
    logic [PALEN-1:0]  s1_paddr;
    logic              s1_hit, s1_inv, s1_ale;
    logic [WAY_W-1:0]  s1_hit_way, s1_inv_way, s1_walk_way, s1_victim, s1_touch;
    logic [TAGW-1:0]   s1_vtag;
    logic [WAYS-1:0]   plru_ext, plru_upd;
    logic [WIDX_W-1:0] s2_widx;
    logic [31:0]       s2_raw, s2_word, s2_ext;
    logic              unused_bits;

    // Handshake: downstream back-pressure reaches s0_ready_o combinationally
    assign s1_adv     = s1_v_q & ~s1_bank_conflict_i & (~s2_v_q | s2_ready_i);
    assign s0_ready_o = ~s1_v_q | s1_adv;
    assign s0_fire    = s0_valid_i & s0_ready_o;
    assign arr_req_o  = s0_fire;

    // Translation
`ifdef LOAD_PIPE_HUGE_PAGE_EN
    assign s1_paddr    = s1_huge_i ? {s1_ppn_i[PALEN-13:9], s1_vaddr_q[20:0]}
                                   : {s1_ppn_i, s1_vaddr_q[11:0]};
    assign unused_bits = ^{s1_vaddr_q[VALEN-1:21], plru_upd[WAYS-1]};
`else
    assign s1_paddr    = {s1_ppn_i, s1_vaddr_q[11:0]};
    assign unused_bits = ^{s1_huge_i, s1_vaddr_q[VALEN-1:12], plru_upd[WAYS-1]};
`endif

    // Hit and first-invalid search; descending loop so the lowest index wins
    always_comb begin : s1_lookup
        s1_hit     = 1'b0;
        s1_hit_way = '0;
        s1_inv     = 1'b0;
        s1_inv_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (s1_meta_valid_i[i] && (s1_tag_i[i*TAGW +: TAGW] == s1_paddr[PALEN-1:TAG_OFFSET])) begin
                s1_hit     = 1'b1;
                s1_hit_way = WAY_W'(i);
            end
            if (!s1_meta_valid_i[i]) begin
                s1_inv     = 1'b1;
                s1_inv_way = WAY_W'(i);
            end
        end
    end

    // Tree-PLRU walk from the root; a 0 bit steers to the lower half
    assign plru_ext = {1'b0, s1_plru_i};
    always_comb begin : s1_plru_walk
        int unsigned node;
        node        = 0;
        s1_walk_way = '0;
        for (int l = 0; l < WAY_W; l++) begin
            s1_walk_way[WAY_W-1-l] = plru_ext[WAY_W'(node)];
            node = 2 * node + 1 + (plru_ext[WAY_W'(node)] ? 1 : 0);
        end
    end

    assign s1_victim = s1_inv ? s1_inv_way : s1_walk_way;
    assign s1_touch  = s1_hit ? s1_hit_way : s1_victim;

    // Every node on the touched way's path is flipped to point away from it
    always_comb begin : s1_plru_update
        int unsigned node;
        node     = 0;
        plru_upd = {1'b0, s1_plru_i};
        for (int l = 0; l < WAY_W; l++) begin
            plru_upd[WAY_W'(node)] = ~s1_touch[WAY_W-1-l];
            node = 2 * node + 1 + (s1_touch[WAY_W-1-l] ? 1 : 0);
        end
    end

    always_comb begin : s1_victim_tag
        s1_vtag = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (WAY_W'(i) == s1_victim) s1_vtag = s1_tag_i[i*TAGW +: TAGW];
        end
    end

    always_comb begin : s1_misalign
        unique case (s1_align_q)
            ALIGN_TYPE_H, ALIGN_TYPE_HU: s1_ale = s1_paddr[0];
            ALIGN_TYPE_W:                s1_ale = |s1_paddr[1:0];
            default:                     s1_ale = 1'b0;
        endcase
    end

    assign s1_data_req_o     = s1_adv;
    assign s1_paddr_o        = s1_paddr;
    assign s1_plru_o         = plru_upd[WAYS-2:0];
    assign s1_plru_we_o      = s1_adv & ~s1_ale;
    assign s1_victim_way_o   = s1_victim;
    assign s1_victim_paddr_o = {s1_vtag, s1_paddr[TAG_OFFSET-1:0]};

    // Stage 2 word select: live bank data in the first cycle, hold register after
    assign s2_widx = (BANK_WORDS > 1) ? s2_paddr_q[WIDX_W+1:2] : '0;
    always_comb begin : s2_select
        s2_raw = '0;
        for (int w = 0; w < WAYS; w++) begin
            for (int k = 0; k < BANK_WORDS; k++) begin
                if ((WAY_W'(w) == s2_way_q) && (WIDX_W'(k) == s2_widx))
                    s2_raw = s2_data_i[(w*BANK_WORDS+k)*32 +: 32];
            end
        end
    end
    assign s2_word = s2_first_q ? s2_raw : s2_hold_q;

    always_comb begin : s2_extend
        logic [7:0]  b;
        logic [15:0] h;
        unique case (s2_paddr_q[1:0])
            2'd0:    b = s2_word[7:0];
            2'd1:    b = s2_word[15:8];
            2'd2:    b = s2_word[23:16];
            default: b = s2_word[31:24];
        endcase
        h = s2_paddr_q[1] ? s2_word[31:16] : s2_word[15:0];
        unique case (s2_align_q)
            ALIGN_TYPE_B:  s2_ext = {{24{b[7]}}, b};
            ALIGN_TYPE_BU: s2_ext = {24'd0, b};
            ALIGN_TYPE_H:  s2_ext = {{16{h[15]}}, h};
            ALIGN_TYPE_HU: s2_ext = {16'd0, h};
            default:       s2_ext = s2_word;
        endcase
    end

    assign s2_valid_o = s2_v_q;
    assign s2_miss_o  = s2_v_q & s2_miss_q;
    assign s2_ale_o   = s2_v_q & s2_ale_q;
    assign s2_paddr_o = s2_paddr_q;
    assign s2_data_o  = (s2_v_q & ~s2_miss_q & ~s2_ale_q) ? s2_ext : 32'd0;

    // Next-state: advances first, flush overrides
    always_comb begin : next_state
        s1_v_d     = s1_v_q;
        s1_vaddr_d = s1_vaddr_q;
        s1_align_d = s1_align_q;
        s2_v_d     = s2_v_q;
        s2_first_d = 1'b0;
        s2_paddr_d = s2_paddr_q;
        s2_align_d = s2_align_q;
        s2_way_d   = s2_way_q;
        s2_miss_d  = s2_miss_q;
        s2_ale_d   = s2_ale_q;
        s2_hold_d  = s2_first_q ? s2_raw : s2_hold_q;
        if (s0_fire) begin
            s1_v_d     = 1'b1;
            s1_vaddr_d = s0_vaddr_i;
            s1_align_d = s0_align_i;
        end else if (s1_adv) begin
            s1_v_d = 1'b0;
        end
        if (s1_adv) begin
            s2_v_d     = 1'b1;
            s2_first_d = 1'b1;
            s2_paddr_d = s1_paddr;
            s2_align_d = s1_align_q;
            s2_way_d   = s1_hit_way;
            s2_miss_d  = ~s1_hit & ~s1_ale;
            s2_ale_d   = s1_ale;
        end else if (s2_ready_i) begin
            s2_v_d = 1'b0;
        end
        if (flush_i) begin
            s1_v_d     = 1'b0;
            s2_v_d     = 1'b0;
            s2_first_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin : regs
        if (rst) begin
            s1_v_q     <= 1'b0;
            s1_vaddr_q <= '0;
            s1_align_q <= '0;
            s2_v_q     <= 1'b0;
            s2_first_q <= 1'b0;
            s2_paddr_q <= '0;
            s2_align_q <= '0;
            s2_way_q   <= '0;
            s2_miss_q  <= 1'b0;
            s2_ale_q   <= 1'b0;
            s2_hold_q  <= '0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_vaddr_q <= s1_vaddr_d;
            s1_align_q <= s1_align_d;
            s2_v_q     <= s2_v_d;
            s2_first_q <= s2_first_d;
            s2_paddr_q <= s2_paddr_d;
            s2_align_q <= s2_align_d;
            s2_way_q   <= s2_way_d;
            s2_miss_q  <= s2_miss_d;
            s2_ale_q   <= s2_ale_d;
            s2_hold_q  <= s2_hold_d;
        end
    end

endmodule
